// File: rtl/car_select.sv
// rtl/car_select.sv - switch-to-IR-car-profile selector
//
// Package consts: CAR_COUNT, IDX_W, the CarSettings struct and the four car
// profiles used by the IR packet generator.
//
// Module car_select: turns the board slide switches into the settings of
// one IR car profile and echoes the selected index on the LEDs.
//   CLK         in   system clock (100 MHz)
//   RESET_N     in   asynchronous active-low reset
//   switches    in   raw car-select switch value [IDX_W-1:0]
//   selectedCar out  CarSettings of the selected car (registered)
//   leds        out  index of the selected car (registered, same edge)
//
// Optional build macro CAR_SELECT_SYNC_EN: switches pass through a 2-flop
// synchronizer and a 16-cycle debouncer before reaching the output
// register (19-cycle latency). Without it the switches are registered
// directly (1-cycle latency).

package consts;
  localparam int CAR_COUNT = 4;
  localparam int IDX_W     = $clog2(CAR_COUNT);

  typedef struct packed {
    logic [15:0] CarrierHz;
    logic [15:0] StartBurstSize;
    logic [15:0] CarSelectBurstSize;
    logic [15:0] GapSize;
    logic [15:0] AssertBurstSize;
    logic [15:0] DeAssertBurstSize;
  } CarSettings;

  localparam CarSettings BLUE_PARAMS   = '{16'd36000, 16'd191, 16'd47, 16'd25, 16'd47, 16'd22};
  localparam CarSettings YELLOW_PARAMS = '{16'd40000, 16'd88,  16'd22, 16'd40, 16'd44, 16'd22};
  localparam CarSettings GREEN_PARAMS  = '{16'd37500, 16'd88,  16'd44, 16'd40, 16'd44, 16'd22};
  localparam CarSettings RED_PARAMS    = '{16'd36000, 16'd192, 16'd24, 16'd24, 16'd48, 16'd24};
endpackage

module car_select
  import consts::*;
(
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [IDX_W-1:0] switches,
  output CarSettings       selectedCar,
  output logic [IDX_W-1:0] leds
);

  // Any unknown or unlisted value falls back to index 0 (BLUE), so the
  // index register never captures X and leds always agree with the profile.
  function automatic logic [IDX_W-1:0] clean_idx(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    case (v)
      2'b00:   r = 2'b00;
      2'b01:   r = 2'b01;
      2'b10:   r = 2'b10;
      2'b11:   r = 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic CarSettings car_of(input logic [IDX_W-1:0] idx);
    CarSettings c;
    case (idx)
      2'b00:   c = BLUE_PARAMS;
      2'b01:   c = YELLOW_PARAMS;
      2'b10:   c = GREEN_PARAMS;
      2'b11:   c = RED_PARAMS;
      default: c = BLUE_PARAMS;
    endcase
    return c;
  endfunction

  logic [IDX_W-1:0] r_idx;
  CarSettings       r_car;
  logic [IDX_W-1:0] w_next_idx;

`ifdef CAR_SELECT_SYNC_EN
  localparam int DEBOUNCE_CYCLES = 16;
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1);

  logic [IDX_W-1:0] r_sync1;
  logic [IDX_W-1:0] r_sync2;
  logic [IDX_W-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_clean;
  logic             w_commit;

  assign w_clean = clean_idx(r_sync2);

  // r_cand is the value currently being timed; r_cnt counts how many
  // consecutive cycles it has been seen. Once it has been stable for
  // DEBOUNCE_CYCLES cycles and is seen once more, it is committed.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= switches;
      r_sync2 <= r_sync1;
      if (w_clean == r_idx) begin
        r_cnt <= '0;
      end else if (w_clean != r_cand) begin
        r_cand <= w_clean;
        r_cnt  <= CNT_W'(1);
      end else if (r_cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_commit   = (w_clean != r_idx) && (w_clean == r_cand) &&
                      (r_cnt == CNT_W'(DEBOUNCE_CYCLES));
  assign w_next_idx = w_commit ? r_cand : r_idx;
`else
  assign w_next_idx = clean_idx(switches);
`endif

  // Index and profile share one register stage so they can never disagree.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_idx <= '0;
      r_car <= BLUE_PARAMS;
    end else begin
      r_idx <= w_next_idx;
      r_car <= car_of(w_next_idx);
    end
  end

  assign leds        = r_idx;
  assign selectedCar = r_car;

endmodule

// File: tb/tb_car_select.sv
// tb/tb_car_select.sv - self-checking bench for car_select
module tb_car_select;
  import consts::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] sw    = 2'b00;
  CarSettings car;
  logic [1:0] leds;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  logic [95:0] prof [4];
  logic [15:0] exp_hz [4];
  logic [1:0]  samp [$];

  always #5 clk = ~clk;

  car_select dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .switches   (sw),
    .selectedCar(car),
    .leds       (leds)
  );

  initial begin
    prof[0] = {16'd36000, 16'd191, 16'd47, 16'd25, 16'd47, 16'd22};
    prof[1] = {16'd40000, 16'd88,  16'd22, 16'd40, 16'd44, 16'd22};
    prof[2] = {16'd37500, 16'd88,  16'd44, 16'd40, 16'd44, 16'd22};
    prof[3] = {16'd36000, 16'd192, 16'd24, 16'd24, 16'd48, 16'd24};
    exp_hz[0] = 16'd36000;
    exp_hz[1] = 16'd40000;
    exp_hz[2] = 16'd37500;
    exp_hz[3] = 16'd36000;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] clean(input logic [1:0] v);
    return $isunknown(v) ? 2'b00 : v;
  endfunction

  // Reference: the outputs show the most recent switch value sampled by a
  // rising edge since reset was last asserted (BLUE/0 if none).
  always @(posedge clk) begin
    if (rst_n) begin
      samp.push_back(clean(sw));
      if (samp.size() > 4) void'(samp.pop_front());
    end
  end

  always @(negedge rst_n) samp.delete();

  always @(negedge clk) begin
    logic [1:0] e;
    if (chk_en) begin
      e = (samp.size() == 0) ? 2'b00 : samp[$];
      check("model_leds", {94'd0, leds}, {94'd0, e});
      check("model_car", car, prof[e]);
    end
  end

  initial begin
`ifdef CAR_SELECT_SYNC_EN
    @(posedge clk); #3 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("sync_idle", {94'd0, leds}, 96'd0);
    // Short bounce must be ignored
    @(posedge clk); #2 sw = 2'b01;
    repeat (5) @(posedge clk);
    #2 sw = 2'b00;
    repeat (30) begin
      @(posedge clk); #1 check("sync_bounce", {94'd0, leds}, 96'd0);
    end
    // Stable change appears exactly 19 edges later
    @(posedge clk); #2 sw = 2'b01;
    for (int n = 1; n <= 19; n++) begin
      @(posedge clk); #1;
      if (n < 19) check("sync_wait", {94'd0, leds}, 96'd0);
      else begin
        check("sync_commit_leds", {94'd0, leds}, 96'd1);
        check("sync_commit_hz", {80'd0, car.CarrierHz}, 96'd40000);
      end
    end
`else
    // Load RED, then assert reset away from any edge
    repeat (3) @(posedge clk);
    #2 sw = 2'b11;
    @(posedge clk); #1;
    check("pre_reset_leds", {94'd0, leds}, 96'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_leds", {94'd0, leds}, 96'd0);
    check("async_reset_hz", {80'd0, car.CarrierHz}, 96'd36000);
    check("async_reset_start", {80'd0, car.StartBurstSize}, 96'd191);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #7 rst_n = 1'b1;

    // Walk all four profiles, each held 10 cycles
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #2 sw = 2'(v);
      @(posedge clk); #1;
      check("walk_leds", {94'd0, leds}, 96'(v));
      check("walk_hz", {80'd0, car.CarrierHz}, {80'd0, exp_hz[v]});
      repeat (8) @(posedge clk);
    end
    #1 check("walk_red_deassert", {80'd0, car.DeAssertBurstSize}, 96'd24);

    // Change every cycle: 00 -> 11 -> 01 -> 10
    begin
      logic [1:0] seq [4];
      seq[0] = 2'b00; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b10;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #2 sw = seq[i];
      end
    end
    @(posedge clk); #1;
    check("fast_leds", {94'd0, leds}, 96'd2);
    check("fast_gap", {80'd0, car.GapSize}, 96'd40);

    // Mid-cycle reset pulse while holding GREEN
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check("pulse_leds", {94'd0, leds}, 96'd0);
    check("pulse_car", car, {16'd36000, 16'd191, 16'd47, 16'd25, 16'd47, 16'd22});
    #2 rst_n = 1'b1;
    #1 check("pulse_hold", {94'd0, leds}, 96'd0);
    @(posedge clk); #1;
    check("pulse_return_leds", {94'd0, leds}, 96'd2);
    check("pulse_return_car", car, {16'd37500, 16'd88, 16'd44, 16'd40, 16'd44, 16'd22});

    // Unknown switch value
    @(posedge clk); #2 sw = 2'bxx;
    repeat (3) @(posedge clk);
    #2 sw = 2'b00;

    // Random switches with occasional mid-cycle reset pulses
    repeat (400) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 2) == 0) sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        #1 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    @(posedge clk);
    chk_en = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
